// File: rtl/bp_pkg.sv
// Shared types and PC index/tag helpers for the branch predictor.
// XLEN up to BP_MAX_W (64) is supported by the helpers and BTB entry type.
package bp_pkg;

  localparam int unsigned BP_MAX_W = 64;

  // 2-bit bimodal counter states.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_t;

  localparam bht_state_t BHT_RESET = WNT;

  // Tag and target are held at the widest supported width, zero-extended.
  typedef struct packed {
    logic                valid;
    logic [BP_MAX_W-1:0] tag;
    logic [BP_MAX_W-1:0] target;
    logic                is_jump;
  } btb_entry_t;

  // Table index: 'bits' PC bits starting above the dropped low bits.
  function automatic logic [BP_MAX_W-1:0] bp_index(input logic [BP_MAX_W-1:0] pc,
                                                   input int unsigned shift,
                                                   input int unsigned bits);
    return (pc >> shift) & ((64'd1 << bits) - 64'd1);
  endfunction

  // Tag: every PC bit above the index field.
  function automatic logic [BP_MAX_W-1:0] bp_tag(input logic [BP_MAX_W-1:0] pc,
                                                 input int unsigned shift,
                                                 input int unsigned bits);
    return pc >> (shift + bits);
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: combinational lookup, single write port.
module bp_btb
  import bp_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned PC_SHIFT = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] rd_pc,
  output logic            rd_hit,
  output logic            rd_is_jump,
  output logic [XLEN-1:0] rd_target,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_pc,
  input  logic [XLEN-1:0] wr_target,
  input  logic            wr_is_jump
);

  localparam int unsigned IW = $clog2(ENTRIES);

  btb_entry_t          btb_q [ENTRIES];
  logic [IW-1:0]       rd_idx;
  logic [IW-1:0]       wr_idx;
  logic [BP_MAX_W-1:0] rd_tag;
  logic [BP_MAX_W-1:0] wr_tag;

  // Index/tag extraction for both ports.
  always_comb begin
    rd_idx = IW'(bp_index(BP_MAX_W'(rd_pc), PC_SHIFT, IW));
    wr_idx = IW'(bp_index(BP_MAX_W'(wr_pc), PC_SHIFT, IW));
    rd_tag = bp_tag(BP_MAX_W'(rd_pc), PC_SHIFT, IW);
    wr_tag = bp_tag(BP_MAX_W'(wr_pc), PC_SHIFT, IW);
  end

  // Lookup reads registered state only, so a same-cycle write is not visible.
  always_comb begin
    rd_hit     = btb_q[rd_idx].valid && (btb_q[rd_idx].tag == rd_tag);
    rd_is_jump = btb_q[rd_idx].is_jump;
    rd_target  = XLEN'(btb_q[rd_idx].target);
  end

  // Storage: async clear, overwrite on allocate (no replacement policy).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) btb_q[i] <= '0;
    end else if (wr_en) begin
      btb_q[wr_idx] <= '{valid: 1'b1, tag: wr_tag,
                         target: BP_MAX_W'(wr_target), is_jump: wr_is_jump};
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal 2-bit BHT + direct-mapped BTB branch predictor.
// Optional BP_STATS_EN adds branch and mispredict counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned BTB_ENTRIES = 16,
  parameter int unsigned PC_SHIFT    = 0,
  parameter int unsigned PC_STEP     = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int unsigned BW = $clog2(BHT_ENTRIES);

  bht_state_t      bht_q [BHT_ENTRIES];
  bht_state_t      bht_cur;
  bht_state_t      bht_nxt;
  logic [BW-1:0]   if_bidx;
  logic [BW-1:0]   ex_bidx;
  logic            btb_hit;
  logic            btb_is_jump;
  logic [XLEN-1:0] btb_target;
  logic            ctrl;
  logic            actual_taken;
  logic            bht_we;
  logic            btb_we;

  bp_btb #(
    .XLEN     (XLEN),
    .ENTRIES  (BTB_ENTRIES),
    .PC_SHIFT (PC_SHIFT)
  ) u_btb (
    .clk        (clk),
    .reset      (reset),
    .rd_pc      (if_pc),
    .rd_hit     (btb_hit),
    .rd_is_jump (btb_is_jump),
    .rd_target  (btb_target),
    .wr_en      (btb_we),
    .wr_pc      (ex_pc),
    .wr_target  (ex_target),
    .wr_is_jump (ex_is_jump)
  );

  // BHT indices for the fetch and resolve sides.
  always_comb begin
    if_bidx = BW'(bp_index(BP_MAX_W'(if_pc), PC_SHIFT, BW));
    ex_bidx = BW'(bp_index(BP_MAX_W'(ex_pc), PC_SHIFT, BW));
  end

  // IF-side prediction from registered tables; forced not-taken in reset.
  always_comb begin
    pred_taken  = reset && btb_hit && (btb_is_jump || bht_q[if_bidx] == WT ||
                                       bht_q[if_bidx] == ST);
    pred_target = pred_taken ? btb_target : if_pc + XLEN'(PC_STEP);
  end

  // EX-side resolution: write enables, mispredict and redirect.
  always_comb begin
    ctrl         = ex_valid && (ex_is_branch || ex_is_jump);
    actual_taken = ex_is_jump || (ex_is_branch && ex_taken);
    bht_we       = ex_valid && ex_is_branch;
    btb_we       = ex_valid && actual_taken;
    mispredict   = reset && ctrl &&
                   ((actual_taken != ex_pred_taken) ||
                    (actual_taken && ex_target != ex_pred_target));
    redirect_pc  = actual_taken ? ex_target : ex_pc + XLEN'(PC_STEP);
  end

  // Saturating counter step for the resolving branch.
  always_comb begin
    bht_cur = bht_q[ex_bidx];
    bht_nxt = bht_cur;
    if (ex_taken) begin
      if (bht_cur != ST) bht_nxt = bht_state_t'(bht_cur + 2'd1);
    end else begin
      if (bht_cur != SNT) bht_nxt = bht_state_t'(bht_cur - 2'd1);
    end
  end

  // BHT storage: async reset to weakly-not-taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= BHT_RESET;
    end else if (bht_we) begin
      bht_q[ex_bidx] <= bht_nxt;
    end
  end

`ifdef BP_STATS_EN
  // Free-running statistics counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (ctrl)       stat_branches    <= stat_branches + 32'd1;
      if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: directed test-plan sequence with literal
// expectations, then random traffic checked against a table model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] if_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        ex_is_branch = 1'b0;
  logic        ex_is_jump = 1'b0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = '0;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_predictor #(
    .XLEN        (32),
    .BHT_ENTRIES (64),
    .BTB_ENTRIES (16),
    .PC_SHIFT    (0),
    .PC_STEP     (1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jump     (ex_is_jump),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc)
`ifdef BP_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counters 0..3 per pc%64; BTB slot pc%16 keyed by pc/16.
  int unsigned m_ctr   [64];
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  bit          m_jump  [16];
  logic [31:0] m_nbr;
  logic [31:0] m_nmp;

  function automatic bit m_pred(input logic [31:0] pc);
    int unsigned s;
    s = pc % 16;
    return m_valid[s] && (m_tag[s] == pc / 16) && (m_jump[s] || m_ctr[pc % 64] >= 2);
  endfunction

  // Compare process: checks every cycle mid-period, then advances the model
  // to what the tables must hold after the next rising edge.
  always @(negedge clk) begin
    bit          ept;
    logic [31:0] etg;
    bit          act;
    bit          emp;
    if (!reset) begin
      for (int i = 0; i < 64; i++) m_ctr[i] = 1;
      for (int i = 0; i < 16; i++) m_valid[i] = 0;
      m_nbr = 0;
      m_nmp = 0;
      chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
      chk("rst_pred_target", pred_target, if_pc + 32'd1);
      chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
`ifdef BP_STATS_EN
      chk("rst_stat_br", stat_branches, 32'd0);
      chk("rst_stat_mp", stat_mispredicts, 32'd0);
`endif
    end else begin
      ept = m_pred(if_pc);
      etg = ept ? m_tgt[if_pc % 16] : if_pc + 32'd1;
      act = ex_is_jump || (ex_is_branch && ex_taken);
      emp = ex_valid && (ex_is_branch || ex_is_jump) &&
            ((act != ex_pred_taken) || (act && ex_target != ex_pred_target));
      chk("pred_taken", {31'd0, pred_taken}, {31'd0, ept});
      chk("pred_target", pred_target, etg);
      chk("mispredict", {31'd0, mispredict}, {31'd0, emp});
      if (emp) chk("redirect_pc", redirect_pc, act ? ex_target : ex_pc + 32'd1);
`ifdef BP_STATS_EN
      chk("stat_br", stat_branches, m_nbr);
      chk("stat_mp", stat_mispredicts, m_nmp);
`endif
      if (ex_valid && (ex_is_branch || ex_is_jump)) begin
        m_nbr = m_nbr + 1;
        if (emp) m_nmp = m_nmp + 1;
        if (ex_is_branch) begin
          if (ex_taken) begin
            if (m_ctr[ex_pc % 64] < 3) m_ctr[ex_pc % 64]++;
          end else if (m_ctr[ex_pc % 64] > 0) m_ctr[ex_pc % 64]--;
        end
        if (act) begin
          m_valid[ex_pc % 16] = 1;
          m_tag[ex_pc % 16]   = ex_pc / 16;
          m_tgt[ex_pc % 16]   = ex_target;
          m_jump[ex_pc % 16]  = ex_is_jump;
        end
      end
    end
  end

  // Drive one cycle's inputs just after the rising edge.
  task automatic drive(input logic [31:0] ipc, input bit v, input logic [31:0] pc,
                       input bit br, input bit jp, input bit tk, input logic [31:0] tg,
                       input bit ptk, input logic [31:0] ptg);
    if_pc = ipc; ex_valid = v; ex_pc = pc; ex_is_branch = br; ex_is_jump = jp;
    ex_taken = tk; ex_target = tg; ex_pred_taken = ptk; ex_pred_target = ptg;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] ipc);
    drive(ipc, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = $urandom_range(0, 63);
    if ($urandom_range(0, 7) == 0) p = 32'hFFFF_FFC0 | p;
    return p;
  endfunction

  initial begin
    logic [31:0] pc;
    logic [31:0] ipc;
    int unsigned kind;
    bit          ptk;

    // Reset held for two cycles.
    idle(32'h10);
    next_cycle();
    next_cycle();
    reset = 1'b1;

    // Cold lookup.
    idle(32'h10);
    chk("lit_cold_pt", {31'd0, pred_taken}, 32'd0);
    chk("lit_cold_tg", pred_target, 32'h11);
    chk("lit_cold_mp", {31'd0, mispredict}, 32'd0);
    next_cycle();

    // Taken branch 0x10 -> 0x40, predicted not-taken.
    drive(32'h10, 1, 32'h10, 1, 0, 1, 32'h40, 0, 32'h11);
    chk("lit_br_mp", {31'd0, mispredict}, 32'd1);
    chk("lit_br_redir", redirect_pc, 32'h40);
    chk("lit_br_same_cycle_pt", {31'd0, pred_taken}, 32'd0);
    next_cycle();

    // Now predicted taken; resolve not-taken (WT -> WNT).
    drive(32'h10, 1, 32'h10, 1, 0, 0, 32'h40, 1, 32'h40);
    chk("lit_trained_pt", {31'd0, pred_taken}, 32'd1);
    chk("lit_trained_tg", pred_target, 32'h40);
    chk("lit_nt1_mp", {31'd0, mispredict}, 32'd1);
    chk("lit_nt1_redir", redirect_pc, 32'h11);
    next_cycle();

    // WNT predicts not-taken; resolve not-taken again (WNT -> SNT).
    drive(32'h10, 1, 32'h10, 1, 0, 0, 32'h40, 0, 32'h11);
    chk("lit_wnt_pt", {31'd0, pred_taken}, 32'd0);
    chk("lit_nt2_mp", {31'd0, mispredict}, 32'd0);
    next_cycle();
    idle(32'h10);
    chk("lit_snt_pt", {31'd0, pred_taken}, 32'd0);
    next_cycle();

    // JALR at 0x20: 0x80 first, then 0x90.
    drive(32'h20, 1, 32'h20, 0, 1, 0, 32'h80, 0, 32'h21);
    chk("lit_j1_mp", {31'd0, mispredict}, 32'd1);
    chk("lit_j1_redir", redirect_pc, 32'h80);
    next_cycle();
    drive(32'h20, 1, 32'h20, 0, 1, 0, 32'h90, 1, 32'h80);
    chk("lit_j_pt", {31'd0, pred_taken}, 32'd1);
    chk("lit_j_tg", pred_target, 32'h80);
    chk("lit_j2_mp", {31'd0, mispredict}, 32'd1);
    chk("lit_j2_redir", redirect_pc, 32'h90);
    next_cycle();
    idle(32'h20);
    chk("lit_j_newtg", pred_target, 32'h90);
    next_cycle();

    // Aliasing in BTB slot 5.
    drive(32'h05, 1, 32'h05, 1, 0, 1, 32'h30, 0, 32'h06);
    next_cycle();
    drive(32'h05, 1, 32'h15, 1, 0, 1, 32'h50, 0, 32'h16);
    chk("lit_alias_pre_pt", {31'd0, pred_taken}, 32'd1);
    next_cycle();
    idle(32'h05);
    chk("lit_alias_miss", {31'd0, pred_taken}, 32'd0);
    next_cycle();
    idle(32'h15);
    chk("lit_alias_hit", {31'd0, pred_taken}, 32'd1);
    chk("lit_alias_tg", pred_target, 32'h50);
    next_cycle();

    // Randomised traffic; ex_pred_* sometimes follow the model's prediction.
    for (int n = 0; n < 3000; n++) begin
      ipc  = rand_pc();
      pc   = rand_pc();
      kind = $urandom_range(0, 4);
      ptk  = ($urandom_range(0, 1) == 1) ? m_pred(pc) : bit'($urandom_range(0, 1));
      drive(ipc, $urandom_range(0, 5) != 0, pc, kind == 1 || kind == 3, kind == 2,
            bit'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? rand_pc() : $urandom(),
            ptk, ($urandom_range(0, 1) == 1) ? m_tgt[pc % 16] : rand_pc());
      if (n == 1500) begin
        reset = 1'b0;
        #1;
        chk("lit_midrst_pt", {31'd0, pred_taken}, 32'd0);
        next_cycle();
        reset = 1'b1;
        idle(32'h20);
        chk("lit_post_rst_pt_20", {31'd0, pred_taken}, 32'd0);
        chk("lit_post_rst_tg_20", pred_target, 32'h21);
`ifdef BP_STATS_EN
        chk("lit_post_rst_stat", stat_branches, 32'd0);
`endif
      end
      next_cycle();
    end

    idle(32'h0);
    next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage RISC-V pipeline.
- IF side: sits beside the PC and supplies a predicted next PC in the same cycle as the fetch.
- EX side: takes the resolved branch/jump outcome, updates its tables, and flags a misprediction with the correct redirect PC.
- Replaces the fixed "predict not-taken, flush on taken" policy with a bimodal 2-bit BHT plus a direct-mapped BTB.

Parameters:
- XLEN, 32: PC/target width.
- BHT_ENTRIES, 64: number of 2-bit counters; power of 2, minimum 2.
- BTB_ENTRIES, 16: number of BTB entries; power of 2, minimum 2.
- PC_SHIFT, 0: low PC bits dropped before indexing. 0 for word-addressed PC (step 1); 2 for byte-addressed PC (step 4).
- PC_STEP, 1: sequential PC increment.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_pc  in  XLEN  PC of the instruction being fetched.
- pred_taken  out  1  predict redirect to pred_target.
- pred_target  out  XLEN  predicted next PC; equals if_pc+PC_STEP when pred_taken=0.
- ex_valid  in  1  EX holds a real (non-bubble) control instruction.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_is_branch  in  1  conditional branch.
- ex_is_jump  in  1  JAL/JALR.
- ex_taken  in  1  actual outcome; ignored when ex_is_jump=1, which is always taken.
- ex_target  in  XLEN  actual taken target.
- ex_pred_taken  in  1  prediction made in IF, carried down the pipe.
- ex_pred_target  in  XLEN  predicted target, carried down the pipe.
- mispredict  out  1  flush IF/ID and ID/EX, load redirect_pc.
- redirect_pc  out  XLEN  correct next PC.

Behaviour:
- Index and tag:
  - bidx = if_pc[PC_SHIFT +: log2(BHT_ENTRIES)].
  - tidx = if_pc[PC_SHIFT +: log2(BTB_ENTRIES)].
  - BTB tag = the remaining upper PC bits.
  - EX side indexes identically from ex_pc.
- Prediction (combinational, zero latency) reads the registered tables:
  - btb_hit = valid && tag match.
  - pred_taken = btb_hit && (entry.is_jump || bht[bidx][1]).
  - pred_target = pred_taken ? entry.target : if_pc+PC_STEP.
- BHT counter encoding: SNT=00, WNT=01, WT=10, ST=11.
- BHT update at posedge, when ex_valid && ex_is_branch:
  - increment on taken, decrement on not-taken.
  - saturate at 11 and 00 (no wrap).
- BTB update at posedge:
  - when ex_valid && (ex_is_jump || (ex_is_branch && ex_taken)), write {valid=1, tag, target=ex_target, is_jump=ex_is_jump}.
  - this overwrites any aliasing entry (direct-mapped, no replacement policy).
  - not-taken branches never allocate.
- actual_taken = ex_is_jump || (ex_is_branch && ex_taken).
- mispredict (combinational) = ex_valid && (ex_is_branch||ex_is_jump) && ((actual_taken != ex_pred_taken) || (actual_taken && ex_target != ex_pred_target)).
  - The target-compare term catches JALR target changes and aliased BTB entries.
- redirect_pc = actual_taken ? ex_target : ex_pc+PC_STEP.
  - Valid only while mispredict=1; don't-care otherwise.
- Write-then-read in the same cycle to the same index: IF reads the old value. No bypass.
- ex_valid=0 or a non-control instruction: no table writes, mispredict=0.
- Adders wrap modulo 2^XLEN.
- Reset (async, reset=0):
  - all BTB valid bits cleared; all BHT counters set to WNT (01).
  - while reset=0: pred_taken=0, pred_target=if_pc+PC_STEP, mispredict=0.
  - mid-operation assertion discards all history immediately; the first cycle after release predicts not-taken everywhere.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - stat_branches increments on every ex_valid control instruction; stat_mispredicts increments on every mispredict.
  - both wrap modulo 2^32 and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package bp_pkg:
  - bht_state_t enum (SNT/WNT/WT/ST).
  - BHT_RESET = WNT.
  - btb_entry_t struct {valid, tag, target, is_jump}.
  - functions for index/tag extraction.
- Sub-module bp_btb: BTB storage, tag compare and write port. The top module holds the BHT and the mispredict logic.

Test Plan:
- Reset, then if_pc=0x10 → pred_taken=0, pred_target=0x11; mispredict=0.
- Branch at ex_pc=0x10, taken, ex_target=0x40, ex_pred_taken=0 → mispredict=1, redirect_pc=0x40. Next cycle if_pc=0x10 → pred_taken=1 (BHT WT), pred_target=0x40.
- Same branch resolved not-taken twice, with ex_pred_taken matching each cycle's prediction → counter WT→WNT→SNT; second resolution mispredict=0. Prediction at 0x10 becomes 0 while the BTB entry stays valid.
- JALR at 0x20: first to 0x80, then to 0x90 with ex_pred_target=0x80 → second resolution mispredict=1, redirect_pc=0x90; BTB target updated to 0x90.
- Aliasing (BTB_ENTRIES=16): taken branch at 0x05→0x30, then at 0x15→0x50 → lookup at 0x05 misses (tag mismatch), pred_taken=0.
- reset pulsed low mid-run after training → pred_taken=0 for all PCs; with BP_STATS_EN, both counters read 0.
